// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute sequencer for register-register ALU, unary
// and multiply/divide instructions on the Phase 1 datapath.
module alu_control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [3:0]  ALUop,
  output logic        ALU_MUL,
  output logic        ALU_DIV,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_FAULT
  } state_t;

  state_t r_state;

  logic [4:0]  w_op;
  logic [15:0] w_ra_sel;
  logic [15:0] w_rb_sel;
  logic [15:0] w_rc_sel;
  logic [3:0]  w_aluop;
  logic        w_alu;
  logic        w_unary;
  logic        w_mul;
  logic        w_div;
  logic        w_muldiv;
  logic        w_last;
  logic        w_unused;

  assign w_op     = IR[31:27];
  assign w_ra_sel = 16'h0001 << IR[26:23];
  assign w_rb_sel = 16'h0001 << IR[22:19];
  assign w_rc_sel = 16'h0001 << IR[18:15];
  assign w_unused = ^IR[14:0];

  always_comb begin
    w_aluop = 4'd0;
    w_alu   = 1'b0;
    w_unary = 1'b0;
    w_mul   = 1'b0;
    w_div   = 1'b0;
    case (w_op)
      5'b00011: begin w_alu = 1'b1; w_aluop = 4'd0; end
      5'b00100: begin w_alu = 1'b1; w_aluop = 4'd1; end
      5'b00101: begin w_alu = 1'b1; w_aluop = 4'd2; end
      5'b00110: begin w_alu = 1'b1; w_aluop = 4'd3; end
      5'b00111: begin w_alu = 1'b1; w_aluop = 4'd4; end
      5'b01000: begin w_alu = 1'b1; w_aluop = 4'd5; end
      5'b01001: begin w_alu = 1'b1; w_aluop = 4'd6; end
      5'b01010: begin w_alu = 1'b1; w_aluop = 4'd7; end
      5'b01011: begin w_alu = 1'b1; w_aluop = 4'd8; end
      5'b10010: begin w_unary = 1'b1; w_aluop = 4'd9; end
      5'b10001: begin w_unary = 1'b1; w_aluop = 4'd10; end
      5'b01111: w_mul = 1'b1;
      5'b10000: w_div = 1'b1;
      default: ;
    endcase
  end

  assign w_muldiv = w_mul | w_div;
  assign w_last   = (r_state == S_T4 && w_unary) ||
                    (r_state == S_T5 && w_alu) ||
                    (r_state == S_T6 && w_muldiv);

  // An opcode that stops matching its class mid-execute also faults.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else if (w_last) begin
      r_state <= run ? S_T0 : S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  r_state <= run ? S_T0 : S_IDLE;
        S_T0:    r_state <= S_T1;
        S_T1:    r_state <= S_T2;
        S_T2:    r_state <= S_T3;
        S_T3:    r_state <= (w_alu | w_unary | w_muldiv) ? S_T4 : S_FAULT;
        S_T4:    r_state <= (w_alu | w_muldiv) ? S_T5 : S_FAULT;
        S_T5:    r_state <= w_muldiv ? S_T6 : S_FAULT;
        S_T6:    r_state <= S_FAULT;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    ALUop    = 4'd0;
    ALU_MUL  = 1'b0;
    ALU_DIV  = 1'b0;
    Rin      = 16'h0000;
    Rout     = 16'h0000;
    unique case (r_state)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (w_alu) begin
          Rout = w_rb_sel;
          Yin  = 1'b1;
        end else if (w_unary) begin
          Rout   = w_rb_sel;
          ALUop  = w_aluop;
          Zlowin = 1'b1;
        end else if (w_muldiv) begin
          Rout = w_ra_sel;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        if (w_alu) begin
          Rout   = w_rc_sel;
          ALUop  = w_aluop;
          Zlowin = 1'b1;
        end else if (w_unary) begin
          Zlowout = 1'b1;
          Rin     = w_ra_sel;
        end else if (w_muldiv) begin
          Rout    = w_rb_sel;
          ALU_MUL = w_mul;
          ALU_DIV = w_div;
          Zlowin  = 1'b1;
          Zhighin = 1'b1;
        end
      end
      S_T5: begin
        if (w_alu) begin
          Zlowout = 1'b1;
          Rin     = w_ra_sel;
        end else if (w_muldiv) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end
      end
      S_T6: begin
        if (w_muldiv) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign done    = w_last;
  assign busy    = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign illegal = (r_state == S_FAULT);

endmodule
